// File: rtl/demux16_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : demux16_deserializer
// Brief    : Collects 16 serial bits into a parallel word, with abort and gaps.
// Revision : 1.0 - initial release
// ============================================================================
module demux16_deserializer #(
    parameter int MSB_FIRST = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic        din_valid,
    input  logic        frame_start,
    output logic [15:0] out,
    output logic        out_valid,
    output logic [3:0]  slot,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    localparam logic [3:0] c_LAST_SLOT = 4'd15;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_shadow;
    logic [15:0] w_shadow_nxt;
    logic [3:0]  r_slot;
    logic [3:0]  w_slot_nxt;
    logic [15:0] r_out;
    logic [15:0] w_out_nxt;
    logic        r_out_valid;
    logic        w_out_valid_nxt;
    logic        r_frame_err;
    logic        w_frame_err_nxt;
    logic        r_busy;
    logic [3:0]  w_wr_slot;
    logic [3:0]  w_wr_idx;

    // A frame_start always restarts at logical slot 0, whatever the current count.
    assign w_wr_slot = frame_start ? 4'd0 : r_slot;
    assign w_wr_idx  = (MSB_FIRST != 0) ? (c_LAST_SLOT - w_wr_slot) : w_wr_slot;

    always_comb begin
        w_state_nxt     = r_state;
        w_shadow_nxt    = r_shadow;
        w_slot_nxt      = r_slot;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_nxt = S_COLLECT;
                    w_slot_nxt  = 4'd0;
                    if (din_valid) begin
                        w_shadow_nxt[w_wr_idx] = din;
                        w_slot_nxt             = 4'd1;
                    end
                end
            end
            S_COLLECT: begin
                if (frame_start) begin
                    // Abort wins even over the slot-15 bit; out is left untouched.
                    w_frame_err_nxt = 1'b1;
                    w_slot_nxt      = 4'd0;
                    if (din_valid) begin
                        w_shadow_nxt[w_wr_idx] = din;
                        w_slot_nxt             = 4'd1;
                    end
                end else if (din_valid) begin
                    w_shadow_nxt[w_wr_idx] = din;
                    if (r_slot == c_LAST_SLOT) begin
                        w_out_nxt       = w_shadow_nxt;
                        w_out_valid_nxt = 1'b1;
                        w_slot_nxt      = 4'd0;
                        w_state_nxt     = S_IDLE;
                    end else begin
                        w_slot_nxt = r_slot + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shadow    <= 16'h0000;
            r_slot      <= 4'd0;
            r_out       <= 16'h0000;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shadow    <= w_shadow_nxt;
            r_slot      <= w_slot_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_busy      <= (w_state_nxt == S_COLLECT);
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign slot      = r_slot;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_demux16_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux16_deserializer
// Brief    : Scoreboard bench driving LSB-first and MSB-first instances in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux16_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] out0, out1;
    logic        out_valid0, out_valid1;
    logic [3:0]  slot0, slot1;
    logic        busy0, busy1;
    logic        frame_err0, frame_err1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int err_cnt  = 0;
    int err_base;

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    demux16_deserializer #(.MSB_FIRST(0)) u_dut0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .out(out0), .out_valid(out_valid0),
        .slot(slot0), .busy(busy0), .frame_err(frame_err0)
    );

    demux16_deserializer #(.MSB_FIRST(1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .out(out1), .out_valid(out_valid1),
        .slot(slot1), .busy(busy1), .frame_err(frame_err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [15:0] d0, input logic [15:0] d1, input int lat);
        exp_t x;
        x.d0  = d0;
        x.d1  = d1;
        x.cyc = cyc + lat;
        sb.push_back(x);
    endtask

    // Sends n bits of v LSB first; optional gap of gap_len idle cycles before bit gap_at.
    task automatic send(input logic [15:0] v, input int n, input bit start,
                        input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    din_valid   = 1'b0;
                    frame_start = 1'b0;
                    @(negedge clk);
                    chk("slot_gap_hold", {28'd0, slot0}, gap_at);
                    step();
                end
            end
            din         = v[i];
            din_valid   = 1'b1;
            frame_start = start && (i == 0);
            step();
        end
        din_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (out_valid0 || out_valid1) begin
            chk("out_valid_agree", {31'd0, out_valid1}, {31'd0, out_valid0});
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out_valid: got out=%h required no pulse (cycle %0d)", out0, cyc);
            end else begin
                e = sb.pop_front();
                chk("out_lsb_first", {16'd0, out0}, {16'd0, e.d0});
                chk("out_msb_first", {16'd0, out1}, {16'd0, e.d1});
                chk("out_valid_cycle", cyc, e.cyc);
            end
        end
        if (frame_err0 || frame_err1) begin
            err_cnt++;
            chk("frame_err_agree", {31'd0, frame_err1}, {31'd0, frame_err0});
            chk("err_excl_valid", {31'd0, out_valid0}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_out0", {16'd0, out0}, 32'h0);
        chk("rst_out1", {16'd0, out1}, 32'h0);
        chk("rst_slot", {28'd0, slot0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err0}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Contiguous frame, first frame after reset
        expect_frame(16'hA5C3, 16'hC3A5, 16);
        send(16'hA5C3, 16, 1'b1, -1, 0);
        @(negedge clk);
        chk("busy_after_frame", {31'd0, busy0}, 32'd0);
        chk("slot_after_frame", {28'd0, slot0}, 32'd0);
        step();
        step();
        @(negedge clk);
        chk("out_held", {16'd0, out0}, 32'hA5C3);
        step();

        // Same frame with a 3-cycle gap after bit 7
        expect_frame(16'hA5C3, 16'hC3A5, 19);
        send(16'hA5C3, 16, 1'b1, 8, 3);
        step();

        // Abort after 10 bits, new frame starts on the abort cycle
        err_base = err_cnt;
        send(16'hFFFF, 10, 1'b1, -1, 0);
        expect_frame(16'h0001, 16'h8000, 16);
        send(16'h0001, 16, 1'b1, -1, 0);
        step();
        @(negedge clk);
        chk("abort_err_count", err_cnt, err_base + 1);
        step();

        // Abort on the cycle that would carry the slot-15 bit
        err_base = err_cnt;
        send(16'hFFFF, 15, 1'b1, -1, 0);
        expect_frame(16'h00FF, 16'hFF00, 16);
        send(16'h00FF, 16, 1'b1, -1, 0);
        step();
        @(negedge clk);
        chk("abort15_err_count", err_cnt, err_base + 1);
        step();

        // Reset in the middle of a frame, then a full frame
        err_base = err_cnt;
        send(16'hFFFF, 9, 1'b1, -1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out", {16'd0, out0}, 32'h0);
        chk("midrst_busy", {31'd0, busy0}, 32'd0);
        chk("midrst_slot", {28'd0, slot0}, 32'd0);
        chk("midrst_no_err", err_cnt, err_base);
        step();
        expect_frame(16'h1234, 16'h2C48, 16);
        send(16'h1234, 16, 1'b1, -1, 0);
        step();

        // Bit sequence 1,0,...,0: LSB-first gives 0001, MSB-first gives 8000
        expect_frame(16'h0001, 16'h8000, 16);
        send(16'h0001, 16, 1'b1, -1, 0);
        step();

        // din_valid toggling in IDLE without frame_start is ignored
        err_base = err_cnt;
        for (int i = 0; i < 40; i++) begin
            din         = ($urandom_range(0, 1) == 1);
            din_valid   = i[0];
            frame_start = 1'b0;
            step();
            @(negedge clk);
            chk("idle_hold", {out0, 11'd0, busy0, slot0}, {16'h0001, 16'h0000});
        end
        din_valid = 1'b0;
        chk("idle_no_err", err_cnt, err_base);

        repeat (3) step();
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
